// File: rtl/demux_scan_sequencer_pkg.sv
// scan_pkg: shared state encoding and channel constants for the demux scan sequencer
package scan_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;
  localparam int N_CHAN = 8;
  localparam int SEL_W = 3;
endpackage

// File: rtl/demux_scan_sequencer_if.sv
// demux_scan_sequencer_if: start/stop control, sweep configuration and demux drive outputs
interface demux_scan_sequencer_if import scan_pkg::*; #(parameter int DWELL_W = 16);
  logic start;
  logic stop;
  logic mode_cont;
  logic [DWELL_W-1:0] dwell;
  logic [N_CHAN-1:0] chan_mask;
  logic [SEL_W-1:0] sel;
  logic en;
  logic busy;
  logic done;
  modport master(output start, stop, mode_cont, dwell, chan_mask, input sel, en, busy, done);
  modport slave(input start, stop, mode_cont, dwell, chan_mask, output sel, en, busy, done);
endinterface

// File: rtl/demux_scan_sequencer_next_chan_find.sv
// next_chan_find: lowest set mask bit above cur, and lowest set bit overall
module next_chan_find import scan_pkg::*; (
  input  logic [N_CHAN-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              found_above,
  output logic [SEL_W-1:0]  first,
  output logic              any
);
  always_comb begin
    nxt = '0;
    first = '0;
    found_above = 1'b0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (mask[i]) first = SEL_W'(i);
      if (mask[i] && SEL_W'(i) > cur) begin
        nxt = SEL_W'(i);
        found_above = 1'b1;
      end
    end
  end
  assign any = |mask;
endmodule

// File: rtl/demux_scan_sequencer.sv
// demux_scan_sequencer: steps demux select through a masked channel set with dwell and blanking
module demux_scan_sequencer import scan_pkg::*; #(
  parameter int DWELL_W = 16,
  parameter int BLANK_CYC = 1
) (
  input logic clk,
  input logic rst,
  demux_scan_sequencer_if.slave bus
);
  localparam int BW = BLANK_CYC > 1 ? $clog2(BLANK_CYC + 1) : 1;
  localparam state_t ENTRY = BLANK_CYC == 0 ? ACTIVE : BLANK;
  localparam logic ENTRY_EN = BLANK_CYC == 0;
  state_t state;
  logic mode_l, en, busy, done, found_above, any;
  logic [DWELL_W-1:0] dwell_l, cnt, dw_in;
  logic [N_CHAN-1:0] mask_l, mask_q;
  logic [BW-1:0] bcnt;
  logic [SEL_W-1:0] sel, nxt, first;
  assign dw_in = bus.dwell == '0 ? DWELL_W'(1) : bus.dwell;
  // In IDLE the finder looks at the live mask so the first channel is ready on the start edge
  assign mask_q = state == IDLE ? bus.chan_mask : mask_l;
  next_chan_find u_find (
    .mask(mask_q),
    .cur(sel),
    .nxt(nxt),
    .found_above(found_above),
    .first(first),
    .any(any)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      mode_l <= 1'b0;
      dwell_l <= '0;
      mask_l <= '0;
      cnt <= '0;
      bcnt <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && bus.stop) begin
        state <= IDLE;
        en <= 1'b0;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start && !bus.stop) begin
            mode_l <= bus.mode_cont;
            dwell_l <= dw_in;
            mask_l <= bus.chan_mask;
            if (!any) done <= 1'b1;
            else begin
              sel <= first;
              busy <= 1'b1;
              state <= ENTRY;
              en <= ENTRY_EN;
              bcnt <= BW'(BLANK_CYC);
              cnt <= dw_in;
            end
          end
          BLANK: if (bcnt == BW'(1)) begin
            state <= ACTIVE;
            en <= 1'b1;
            cnt <= dwell_l;
          end else bcnt <= bcnt - 1'b1;
          ACTIVE: if (cnt == DWELL_W'(1)) begin
            if (found_above || mode_l) begin
              sel <= found_above ? nxt : first;
              state <= ENTRY;
              en <= ENTRY_EN;
              bcnt <= BW'(BLANK_CYC);
              cnt <= dwell_l;
            end else begin
              state <= IDLE;
              en <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end else cnt <= cnt - 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign bus.sel = sel;
  assign bus.en = en;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
